parallel2serial: RTL

- Counterpart of the serial-to-parallel input stage.
- Takes a snapshot of one WIDTH-bit value per wind turbine from a flattened parallel bus (e.g. per-turbine P/Q results) on a start pulse.
- Emits the values one word at a time on a single serial bus with an address tag, then pulses done.
- Sits between the per-turbine computation units and the metering/exchange interface.

---
 rtl/parallel2serial_if.sv | 32 +++
 rtl/parallel2serial.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/parallel2serial_if.sv
//----------------------------------------------------------------------------
// Module      : parallel2serial_if
// Description : Bus bundle for parallel2serial (start/snapshot in, serial out).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface parallel2serial_if #(
    parameter int WIDTH      = 32,
    parameter int N          = 4,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  sta;
    logic [N*WIDTH-1:0]    P_in;
    logic [WIDTH-1:0]      data_out;
    logic [ADDR_WIDTH-1:0] addr_out;
    logic                  valid_out;
    logic                  busy;
    logic                  done_sig;

    modport master (
        output sta, P_in,
        input  data_out, addr_out, valid_out, busy, done_sig
    );

    modport slave (
        input  sta, P_in,
        output data_out, addr_out, valid_out, busy, done_sig
    );
endinterface

`default_nettype wire

// File: rtl/parallel2serial.sv
//----------------------------------------------------------------------------
// Module      : parallel2serial
// Description : Snapshots N words on sta and streams them out one per TIMES
//               clocks with an address tag, then pulses done_sig.
//               Optional macro P2S_PENDING_START_EN queues a start seen while busy.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module parallel2serial #(
    parameter int WIDTH      = 32,
    parameter int N          = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMES      = 1,
    parameter int INI_ADDR   = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    parallel2serial_if.slave   bus
);

    localparam int IDX_W  = (N > 1)     ? $clog2(N)     : 1;
    localparam int SLOT_W = (TIMES > 1) ? $clog2(TIMES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0]      C_LAST_IDX  = IDX_W'(N - 1);
    localparam logic [SLOT_W-1:0]     C_LAST_SLOT = SLOT_W'(TIMES - 1);
    localparam logic [ADDR_WIDTH-1:0] C_BASE_ADDR = ADDR_WIDTH'(INI_ADDR);

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [N*WIDTH-1:0]    snap_q, snap_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]      w_next_idx;
    logic                  w_start;
    logic                  w_pend;

    assign w_next_idx = idx_q + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            slot_q  <= '0;
            snap_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic; data/addr are loaded one edge ahead of their valid cycle
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        snap_d  = snap_q;
        data_d  = data_q;
        addr_d  = addr_q;
        w_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_start = bus.sta | w_pend;
            end
            ST_SEND: begin
                // The last word has no trailing slot cycles: go straight to DONE
                if (idx_q == C_LAST_IDX) begin
                    state_d = ST_DONE;
                end else if (slot_q == C_LAST_SLOT) begin
                    slot_d = '0;
                    idx_d  = w_next_idx;
                    data_d = snap_q[int'(w_next_idx)*WIDTH +: WIDTH];
                    addr_d = C_BASE_ADDR + ADDR_WIDTH'(w_next_idx);
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            ST_DONE: begin
                w_start = w_pend;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_start) begin
            state_d = ST_SEND;
            snap_d  = bus.P_in;
            idx_d   = '0;
            slot_d  = '0;
            data_d  = bus.P_in[WIDTH-1:0];
            addr_d  = C_BASE_ADDR;
        end
    end

`ifdef P2S_PENDING_START_EN
    logic pend_q, pend_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // A start consumed this edge absorbs any concurrent sta pulse
    always_comb begin
        pend_d = pend_q;
        if (w_start) begin
            pend_d = 1'b0;
        end else if (bus.sta && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end
    end

    assign w_pend = pend_q;
`else
    assign w_pend = 1'b0;
`endif

    // Output logic
    always_comb begin
        bus.valid_out = (state_q == ST_SEND) && (slot_q == '0);
        bus.busy      = (state_q != ST_IDLE);
        bus.done_sig  = (state_q == ST_DONE);
        bus.data_out  = data_q;
        bus.addr_out  = addr_q;
    end

endmodule

`default_nettype wire
